mem_arbiter: RTL and testbench

- Sequences the processor's three memory micro-operations onto one shared single-port memory with a req/ack handshake.
  - read and write go through the word port (MAR/MDR).
  - fetch goes through the byte port (PC/MBR).
- Holds one pending request per port and arbitrates round-robin between ports.
- Returns read data with a valid pulse and flags protocol errors.
- Sits between the processor's word_address/word_data/byte_address/byte_data pins and the memory model or bus.

---
 rtl/ijvm_mem_pkg.sv | 13 +
 rtl/mem_timeout_counter.sv | 45 ++++
 rtl/mem_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ijvm_mem_pkg.sv
// Shared types and default widths for the processor's memory arbiter.
// Used by the arbiter top and by its testbench.
package ijvm_mem_pkg;

   typedef enum logic [1:0] {IDLE, BUSY_W, BUSY_B} state_e;
   typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_FETCH} op_e;
   typedef enum logic {PORT_WORD, PORT_BYTE} port_e;

   localparam int DEF_DATA_W         = 32;
   localparam int DEF_ADDR_W         = 32;
   localparam int DEF_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts cycles of an outstanding memory request.
// expired flags the last allowed cycle; it is tied low when TIMEOUT_CYCLES is 0.
module mem_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   input  logic clear,
   output logic expired
);

   generate
      if (TIMEOUT_CYCLES == 0) begin : g_off
         logic unused_inputs;
         assign unused_inputs = clk ^ reset ^ run ^ clear;
         assign expired       = 1'b0;
      end else begin : g_on
         localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
         localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

         logic [CW-1:0] cnt_q, cnt_d;

         always_comb begin
            cnt_d = cnt_q;
            if (clear) begin
               cnt_d = '0;
            end else if (run) begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end

         assign expired = run && (cnt_q == LAST);
      end
   endgenerate

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates word read/write and byte fetch micro-operations onto one
// single-port memory, one pending request per port, round-robin on contention.
module mem_arbiter
   import ijvm_mem_pkg::*;
#(
   parameter int DATA_W         = DEF_DATA_W,
   parameter int ADDR_W         = DEF_ADDR_W,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              read,
   input  logic              write,
   input  logic              fetch,
   input  logic [ADDR_W-1:0] word_address,
   input  logic [DATA_W-1:0] word_wdata,
   input  logic [ADDR_W-1:0] byte_address,
   output logic [DATA_W-1:0] word_rdata,
   output logic              word_rvalid,
   output logic [7:0]        byte_rdata,
   output logic              byte_rvalid,
   output logic              stall_word,
   output logic              stall_byte,
   output logic              err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output state_e            dbg_state
);

   state_e              state_q, state_d;
   port_e               rr_q, rr_d;
   logic                contended_q, contended_d;
   logic                wvalid_q, wvalid_d;
   op_e                 wop_q, wop_d;
   logic [ADDR_W-3:0]   waddr_q, waddr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                bvalid_q, bvalid_d;
   logic [ADDR_W-1:0]   baddr_q, baddr_d;
   logic [DATA_W-1:0]   word_rdata_q, word_rdata_d;
   logic                word_rvalid_q, word_rvalid_d;
   logic [7:0]          byte_rdata_q, byte_rdata_d;
   logic                byte_rvalid_q, byte_rvalid_d;
   logic                err_q, err_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

   logic                busy, finish, timed_out, expired;
   logic                word_done, byte_done;
   logic [7:0]          lane_byte;
   logic                unused_word_addr;

   assign unused_word_addr = ^word_address[ADDR_W-1:ADDR_W-2];

   // mem_req/mem_ack: mem_req rises with we/addr/wdata loaded and holds them
   // stable until the cycle mem_ack is seen high (or the timeout fires);
   // mem_ack sampled while mem_req is low has no effect.
   assign busy      = (state_q != IDLE);
   assign finish    = busy && (mem_ack || expired);
   assign timed_out = finish && !mem_ack;
   assign word_done = finish && (state_q == BUSY_W);
   assign byte_done = finish && (state_q == BUSY_B);

   mem_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .run    (busy),
      .clear  (finish),
      .expired(expired)
   );

   // Big-endian lane: byte offset 0 is the most significant byte of the word.
   always_comb begin
      case (baddr_q[1:0])
         2'd0:    lane_byte = mem_rdata[DATA_W-1  -: 8];
         2'd1:    lane_byte = mem_rdata[DATA_W-9  -: 8];
         2'd2:    lane_byte = mem_rdata[DATA_W-17 -: 8];
         default: lane_byte = mem_rdata[DATA_W-25 -: 8];
      endcase
   end

   always_comb begin
      state_d       = state_q;
      rr_d          = rr_q;
      contended_d   = contended_q;
      wvalid_d      = wvalid_q;
      wop_d         = wop_q;
      waddr_d       = waddr_q;
      wdata_d       = wdata_q;
      bvalid_d      = bvalid_q;
      baddr_d       = baddr_q;
      word_rdata_d  = word_rdata_q;
      word_rvalid_d = 1'b0;
      byte_rdata_d  = byte_rdata_q;
      byte_rvalid_d = 1'b0;
      err_d         = err_q;
      mem_req_d     = mem_req_q;
      mem_we_d      = mem_we_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;

      case (state_q)
         IDLE: begin
            if (wvalid_q && (!bvalid_q || rr_q == PORT_WORD)) begin
               state_d     = BUSY_W;
               mem_req_d   = 1'b1;
               mem_we_d    = (wop_q == OP_WRITE);
               mem_addr_d  = {waddr_q, 2'b00};
               mem_wdata_d = wdata_q;
               contended_d = bvalid_q;
            end else if (bvalid_q) begin
               state_d     = BUSY_B;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = {baddr_q[ADDR_W-1:2], 2'b00};
               contended_d = wvalid_q;
            end
         end
         BUSY_W: begin
            if (finish) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               wvalid_d  = 1'b0;
               if (wop_q == OP_READ) begin
                  word_rvalid_d = 1'b1;
                  word_rdata_d  = timed_out ? '0 : mem_rdata;
               end
               if (contended_q) rr_d = PORT_BYTE;
            end
         end
         BUSY_B: begin
            if (finish) begin
               state_d       = IDLE;
               mem_req_d     = 1'b0;
               bvalid_d      = 1'b0;
               byte_rvalid_d = 1'b1;
               byte_rdata_d  = timed_out ? 8'h00 : lane_byte;
               if (contended_q) rr_d = PORT_WORD;
            end
         end
         default: state_d = IDLE;
      endcase

      if (timed_out) err_d = 1'b1;

      // A slot freed on this edge can take a new request on the same edge.
      if (read && write) err_d = 1'b1;
      if (read || write) begin
         if (!wvalid_q || word_done) begin
            wvalid_d = 1'b1;
            wop_d    = write ? OP_WRITE : OP_READ;
            waddr_d  = word_address[ADDR_W-3:0];
            wdata_d  = word_wdata;
         end else begin
            err_d = 1'b1;
         end
      end
      if (fetch) begin
         if (!bvalid_q || byte_done) begin
            bvalid_d = 1'b1;
            baddr_d  = byte_address;
         end else begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         rr_q          <= PORT_WORD;
         contended_q   <= 1'b0;
         wvalid_q      <= 1'b0;
         wop_q         <= OP_READ;
         waddr_q       <= '0;
         wdata_q       <= '0;
         bvalid_q      <= 1'b0;
         baddr_q       <= '0;
         word_rdata_q  <= '0;
         word_rvalid_q <= 1'b0;
         byte_rdata_q  <= '0;
         byte_rvalid_q <= 1'b0;
         err_q         <= 1'b0;
         mem_req_q     <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
      end else begin
         state_q       <= state_d;
         rr_q          <= rr_d;
         contended_q   <= contended_d;
         wvalid_q      <= wvalid_d;
         wop_q         <= wop_d;
         waddr_q       <= waddr_d;
         wdata_q       <= wdata_d;
         bvalid_q      <= bvalid_d;
         baddr_q       <= baddr_d;
         word_rdata_q  <= word_rdata_d;
         word_rvalid_q <= word_rvalid_d;
         byte_rdata_q  <= byte_rdata_d;
         byte_rvalid_q <= byte_rvalid_d;
         err_q         <= err_d;
         mem_req_q     <= mem_req_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
      end
   end

   assign word_rdata  = word_rdata_q;
   assign word_rvalid = word_rvalid_q;
   assign byte_rdata  = byte_rdata_q;
   assign byte_rvalid = byte_rvalid_q;
   assign stall_word  = wvalid_q;
   assign stall_byte  = bvalid_q;
   assign err         = err_q;
   assign mem_req     = mem_req_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios with literal expectations plus
// randomized traffic against a transaction-level model of slots and grants.
module tb_mem_arbiter;
   import ijvm_mem_pkg::*;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        read = 1'b0, write = 1'b0, fetch = 1'b0;
   logic [31:0] word_address = '0, word_wdata = '0, byte_address = '0;
   logic [31:0] word_rdata;
   logic        word_rvalid;
   logic [7:0]  byte_rdata;
   logic        byte_rvalid;
   logic        stall_word, stall_byte, err;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   state_e      dbg_state;

   int n_checks = 0;
   int n_errors = 0;

   mem_arbiter #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .read(read), .write(write), .fetch(fetch),
      .word_address(word_address), .word_wdata(word_wdata), .byte_address(byte_address),
      .word_rdata(word_rdata), .word_rvalid(word_rvalid),
      .byte_rdata(byte_rdata), .byte_rvalid(byte_rvalid),
      .stall_word(stall_word), .stall_byte(stall_byte), .err(err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // ---------------- memory responder (stimulus) ----------------
   int          resp_mode = 1;   // 0 random delay 0..5, 1 zero-wait, 2 never ack
   logic        late_ack = 1'b0;
   logic        fixed_en = 1'b0;
   logic [31:0] fixed_data = '0;
   logic        in_req = 1'b0;
   int          wait_cnt = 0;

   always @(posedge clk) begin
      #1;
      if (!reset) begin
         mem_ack = 1'b0;
         in_req  = 1'b0;
      end else if (mem_req) begin
         if (!in_req) begin
            in_req   = 1'b1;
            wait_cnt = (resp_mode == 0) ? int'($urandom_range(0, 5)) : 0;
         end
         if (resp_mode != 2 && wait_cnt == 0) begin
            mem_ack = 1'b1;
         end else begin
            mem_ack = 1'b0;
            if (wait_cnt > 0) wait_cnt--;
         end
      end else begin
         in_req  = 1'b0;
         mem_ack = (resp_mode == 0) ? ($urandom_range(0, 3) == 0) : late_ack;
      end
      mem_rdata = fixed_en ? fixed_data : $urandom();
   end

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic        v;
      logic        is_wr;
      logic [31:0] addr;
      logic [31:0] data;
   } wslot_t;

   typedef struct packed {
      logic        v;
      logic [31:0] addr;
   } bslot_t;

   wslot_t      ws;
   bslot_t      bs;
   int          m_active;      // 0 none, 1 word, 2 byte
   int          m_age;
   int          m_pref;        // 0 word wins next contention, 1 byte wins
   bit          m_contended;
   logic        m_err, m_wrv, m_brv, m_req_we;
   logic [31:0] m_wrdata, m_req_addr, m_req_wdata;
   logic [7:0]  m_brdata;
   logic [31:0] exp_q[$];
   logic [7:0]  exp_bq[$];

   function automatic logic [7:0] lane_of(input logic [31:0] d, input logic [1:0] off);
      return 8'(d >> (8 * (3 - int'(off))));
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         ws = '0; bs = '0;
         m_active = 0; m_age = 0; m_pref = 0; m_contended = 0;
         m_err = 0; m_wrv = 0; m_brv = 0; m_wrdata = '0; m_brdata = '0;
         m_req_we = 0; m_req_addr = '0; m_req_wdata = '0;
         exp_q.delete(); exp_bq.delete();
      end else begin
         bit wdone, bdone, tmo;
         wdone = 0; bdone = 0;
         m_wrv = 0; m_brv = 0;
         if (m_active != 0) begin
            if (mem_ack || m_age == TO - 1) begin
               tmo = !mem_ack;
               if (tmo) m_err = 1;
               if (m_active == 1) begin
                  wdone = 1;
                  if (!ws.is_wr) begin
                     m_wrv = 1;
                     m_wrdata = tmo ? 32'h0 : mem_rdata;
                     exp_q.push_back(m_wrdata);
                  end
               end else begin
                  bdone = 1;
                  m_brv = 1;
                  m_brdata = tmo ? 8'h0 : lane_of(mem_rdata, bs.addr[1:0]);
                  exp_bq.push_back(m_brdata);
               end
               if (m_contended) m_pref = (m_active == 1) ? 1 : 0;
               m_active = 0;
            end else begin
               m_age++;
            end
         end else if (ws.v || bs.v) begin
            m_contended = ws.v && bs.v;
            m_age = 0;
            if (ws.v && (!bs.v || m_pref == 0)) begin
               m_active = 1;
               m_req_we = ws.is_wr;
               m_req_addr = ws.addr * 4;
               m_req_wdata = ws.data;
            end else begin
               m_active = 2;
               m_req_we = 0;
               m_req_addr = bs.addr & 32'hFFFF_FFFC;
            end
         end
         if (wdone) ws.v = 0;
         if (bdone) bs.v = 0;
         if (read && write) m_err = 1;
         if (read || write) begin
            if (!ws.v) ws = '{v: 1'b1, is_wr: write, addr: word_address, data: word_wdata};
            else m_err = 1;
         end
         if (fetch) begin
            if (!bs.v) bs = '{v: 1'b1, addr: byte_address};
            else m_err = 1;
         end
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      chk("mem_req", mem_req, m_active != 0);
      chk("stall_word", stall_word, ws.v);
      chk("stall_byte", stall_byte, bs.v);
      chk("err", err, m_err);
      chk("word_rvalid", word_rvalid, m_wrv);
      chk("byte_rvalid", byte_rvalid, m_brv);
      chk("word_rdata", word_rdata, m_wrdata);
      chk("byte_rdata", byte_rdata, m_brdata);
      if (m_active != 0) begin
         chk("mem_we", mem_we, m_req_we);
         chk("mem_addr", mem_addr, m_req_addr);
         if (m_req_we) chk("mem_wdata", mem_wdata, m_req_wdata);
      end
      if (word_rvalid) begin
         if (exp_q.size() == 0) chk("sb_word_unexpected", 1, 0);
         else chk("sb_word", word_rdata, exp_q.pop_front());
      end
      if (byte_rvalid) begin
         if (exp_bq.size() == 0) chk("sb_byte_unexpected", 1, 0);
         else chk("sb_byte", byte_rdata, exp_bq.pop_front());
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      read = 0; write = 0; fetch = 0;
   endtask

   task automatic wait_req(input int budget, output logic [31:0] addr);
      bit seen;
      seen = 0;
      for (int i = 0; i < budget && !seen; i++) begin
         if (mem_req) seen = 1;
         else tick();
      end
      if (!seen) chk("wait_req_timeout", 0, 1);
      addr = mem_addr;
   endtask

   task automatic do_fetch_lane(input logic [31:0] addr, input logic [31:0] data,
                                input logic [31:0] exp_addr, input logic [7:0] exp_byte);
      fixed_en = 1; fixed_data = data;
      fetch = 1; byte_address = addr;
      tick(); clr();
      tick();
      chk("lane_mem_addr", mem_addr, exp_addr);
      tick();
      chk("lane_rvalid", byte_rvalid, 1);
      chk("lane_rdata", byte_rdata, exp_byte);
      tick();
   endtask

   task automatic contention(input logic [31:0] first, input logic [31:0] second, input bit word_first);
      logic [31:0] a;
      read = 1; word_address = 32'h20;
      fetch = 1; byte_address = 32'h205;
      tick(); clr();
      wait_req(10, a);
      chk("rr_first_grant", a, first);
      tick();
      chk("rr_first_stall_w", stall_word, !word_first);
      chk("rr_first_stall_b", stall_byte, word_first);
      wait_req(10, a);
      chk("rr_second_grant", a, second);
      tick();
      chk("rr_done_stall_w", stall_word, 0);
      chk("rr_done_stall_b", stall_byte, 0);
      tick();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int nreq;
      logic [31:0] a;

      // reset held with random request pulses
      for (int i = 0; i < 6; i++) begin
         tick();
         read = $urandom_range(0, 1); write = $urandom_range(0, 1); fetch = $urandom_range(0, 1);
         word_address = $urandom(); byte_address = $urandom(); word_wdata = $urandom();
         chk("rst_mem_addr", mem_addr, 0);
         chk("rst_mem_wdata", mem_wdata, 0);
         chk("rst_mem_we", mem_we, 0);
         chk("rst_state", dbg_state, IDLE);
      end
      clr();
      reset = 1;
      tick();

      // zero-wait read
      resp_mode = 1; fixed_en = 1; fixed_data = 32'hDEADBEEF;
      read = 1; word_address = 32'h10;
      tick(); clr();
      chk("rd_stall", stall_word, 1);
      chk("rd_req_early", mem_req, 0);
      tick();
      chk("rd_req", mem_req, 1);
      chk("rd_addr", mem_addr, 32'h40);
      chk("rd_we", mem_we, 0);
      tick();
      chk("rd_rvalid", word_rvalid, 1);
      chk("rd_rdata", word_rdata, 32'hDEADBEEF);
      tick();
      chk("rd_rvalid_pulse", word_rvalid, 0);

      // big-endian byte lanes
      do_fetch_lane(32'h103, 32'h11223344, 32'h100, 8'h44);
      do_fetch_lane(32'h100, 32'h11223344, 32'h100, 8'h11);

      // round-robin contention
      fixed_en = 0;
      contention(32'h80, 32'h204, 1);
      contention(32'h204, 32'h80, 0);

      // write+read collision and drop on busy byte slot
      chk("err_clean", err, 0);
      read = 1; write = 1; word_address = 32'h7; word_wdata = 32'hCAFEF00D;
      tick(); clr();
      chk("rw_err", err, 1);
      tick();
      chk("rw_req", mem_req, 1);
      chk("rw_we", mem_we, 1);
      chk("rw_addr", mem_addr, 32'h1C);
      chk("rw_wdata", mem_wdata, 32'hCAFEF00D);
      tick();
      chk("rw_silent", word_rvalid, 0);
      tick();
      fetch = 1; byte_address = 32'h42;
      tick();
      fetch = 1; byte_address = 32'h50;
      tick(); clr();
      chk("drop_stall_b", stall_byte, 1);
      chk("drop_addr", mem_addr, 32'h40);
      tick();
      nreq = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (mem_req) nreq++;
      end
      chk("drop_no_second", nreq, 0);
      chk("drop_err_sticky", err, 1);

      // reset during an outstanding request
      resp_mode = 2;
      read = 1; word_address = 32'h5;
      tick(); clr();
      tick();
      chk("mid_req", mem_req, 1);
      #2;
      reset = 0;
      #1;
      chk("mid_async_req", mem_req, 0);
      chk("mid_async_stall", stall_word, 0);
      @(posedge clk); @(posedge clk);
      #1;
      reset = 1;
      nreq = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (mem_req || word_rvalid || stall_word) nreq++;
      end
      chk("mid_quiet", nreq, 0);

      // preload nonzero read data, then timeout abort
      resp_mode = 1; fixed_en = 1; fixed_data = 32'hA5A5A5A5;
      read = 1; word_address = 32'h9;
      tick(); clr(); tick(); tick(); tick();
      chk("pre_rdata", word_rdata, 32'hA5A5A5A5);
      resp_mode = 2;
      chk("to_err_clean", err, 0);
      read = 1; word_address = 32'h3;
      tick(); clr();
      for (int i = 0; i < TO; i++) begin
         tick();
         chk("to_req_held", mem_req, 1);
      end
      tick();
      chk("to_req_drop", mem_req, 0);
      chk("to_rvalid", word_rvalid, 1);
      chk("to_rdata", word_rdata, 0);
      chk("to_err", err, 1);
      late_ack = 1;
      nreq = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (word_rvalid || mem_req) nreq++;
      end
      chk("late_ack_ignored", nreq, 0);
      late_ack = 0;

      // randomized traffic
      resp_mode = 0; fixed_en = 0;
      for (int i = 0; i < 1500; i++) begin
         int r;
         r = $urandom_range(0, 99);
         read  = (r < 15);
         write = (r >= 10 && r < 25);
         fetch = ($urandom_range(0, 99) < 20);
         word_address = $urandom();
         word_wdata   = $urandom();
         byte_address = $urandom();
         tick();
      end
      clr();
      for (int i = 0; i < 40; i++) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
